// File: rtl/uart_comm_param_if.sv
// CPU-side word interface of uart_comm_param: TX push port and FWFT RX pop port.
// Master is the CPU/bench side, slave is the UART.
interface uart_comm_param_if #(
  parameter int unsigned DATA_BITS = 8
);
  logic                 send_flag;
  logic [DATA_BITS-1:0] send_data;
  logic                 recv_flag;
  logic [DATA_BITS-1:0] recv_data;
  logic                 sendable;
  logic                 receivable;

  modport master (
    output send_flag, send_data, recv_flag,
    input  recv_data, sendable, receivable
  );

  modport slave (
    input  send_flag, send_data, recv_flag,
    output recv_data, sendable, receivable
  );
endinterface

// File: rtl/uart_comm_param.sv
// Parametrised full-duplex UART with TX/RX FIFOs, runtime parity/stop selection and sticky RX errors.
// Optional macro UART_LOOPBACK_EN adds a 'loopback' input routing internal TX serial into RX.

module uart_comm_param_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_head,
  output logic             o_not_empty,
  output logic             o_not_full
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr;
  logic [AW-1:0]    r_rd;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_head;
  logic             w_pop;
  logic             w_push;

  assign w_pop       = i_pop && (r_cnt != '0);
  assign w_push      = i_push && ((r_cnt != CW'(DEPTH)) || w_pop);
  assign o_head      = r_head;
  assign o_not_empty = (r_cnt != '0);
  assign o_not_full  = (r_cnt != CW'(DEPTH));

  always_ff @(posedge CLK) begin
    if (w_push) r_mem[r_wr] <= i_wdata;
  end

  // Head is registered so it resets to zero; it tracks the word that will be at rd after this cycle.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      r_wr   <= '0;
      r_rd   <= '0;
      r_cnt  <= '0;
      r_head <= '0;
    end else begin
      if (w_push) r_wr <= r_wr + AW'(1);
      if (w_pop)  r_rd <= r_rd + AW'(1);
      if (w_push && !w_pop)      r_cnt <= r_cnt + CW'(1);
      else if (w_pop && !w_push) r_cnt <= r_cnt - CW'(1);
      if (r_cnt == '0) begin
        if (w_push) r_head <= i_wdata;
      end else if (w_pop) begin
        if (r_cnt == CW'(1)) begin
          if (w_push) r_head <= i_wdata;
        end else begin
          r_head <= r_mem[r_rd + AW'(1)];
        end
      end
    end
  end
endmodule

module uart_comm_param #(
  parameter int unsigned CLOCKRATE  = 80000000,
  parameter int unsigned BAUDRATE   = 9600,
  parameter int unsigned OVERSAMPLE = 16,
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned FIFO_DEPTH = 16
) (
  input  logic                CLK,
  input  logic                RST_N,
  uart_comm_param_if.slave    bus,
  input  logic [1:0]          parity_mode,
  input  logic                stop2,
  input  logic                err_clr,
  output logic                parity_err,
  output logic                frame_err,
  output logic                overrun,
  output logic                Tx,
  input  logic                Rx
`ifdef UART_LOOPBACK_EN
  , input logic               loopback
`endif
);
  localparam int unsigned DIV_RAW = CLOCKRATE / (BAUDRATE * OVERSAMPLE);
  localparam int unsigned DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
  localparam int unsigned DW      = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned TW      = $clog2(OVERSAMPLE);
  localparam int unsigned BW      = $clog2(DATA_BITS);

  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP1, RX_STOP2} rx_state_t;
  typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP1, TX_STOP2} tx_state_t;

  logic [DW-1:0] r_div;
  logic          w_tick;
  logic          w_rx_pin;
  logic          r_tx;

  assign w_tick = (r_div == DW'(DIV - 1));

  always_ff @(posedge CLK) begin
    if (!RST_N || w_tick) r_div <= '0;
    else                  r_div <= r_div + DW'(1);
  end

`ifdef UART_LOOPBACK_EN
  assign w_rx_pin = loopback ? r_tx : Rx;
  assign Tx       = loopback ? 1'b1 : r_tx;
`else
  assign w_rx_pin = Rx;
  assign Tx       = r_tx;
`endif

  // ---------------- RX front end ----------------
  logic       r_rx_s1, r_rx_s2, r_rx_prev;
  logic [2:0] r_rx_hist;
  logic       w_rx_bit;

  assign w_rx_bit = (r_rx_hist[0] & r_rx_hist[1]) | (r_rx_hist[1] & r_rx_hist[2]) |
                    (r_rx_hist[0] & r_rx_hist[2]);

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      r_rx_s1   <= 1'b1;
      r_rx_s2   <= 1'b1;
      r_rx_hist <= '1;
      r_rx_prev <= 1'b1;
    end else begin
      r_rx_s1 <= w_rx_pin;
      r_rx_s2 <= r_rx_s1;
      if (w_tick) begin
        r_rx_hist <= {r_rx_hist[1:0], r_rx_s2};
        r_rx_prev <= w_rx_bit;
      end
    end
  end

  // ---------------- RX FSM ----------------
  rx_state_t            r_rx_state, w_rx_state_n;
  logic [TW-1:0]        r_rx_tcnt, w_rx_tcnt_n, w_rx_limit;
  logic [BW-1:0]        r_rx_bit, w_rx_bit_n;
  logic [DATA_BITS-1:0] r_rx_shift, w_rx_shift_n;
  logic [1:0]           r_rx_mode, w_rx_mode_n;
  logic                 r_rx_stop2, w_rx_stop2_n;
  logic                 r_rx_perr, w_rx_perr_n;
  logic                 w_rx_push, w_perr_set, w_ferr_set, w_ovr_set;
  logic                 w_rx_not_full;

  assign w_rx_limit = (r_rx_state == RX_START) ? TW'(OVERSAMPLE / 2 - 1) : TW'(OVERSAMPLE - 1);
  assign w_ovr_set  = w_rx_push && !w_rx_not_full && !bus.recv_flag;

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      r_rx_state <= RX_IDLE;
      r_rx_tcnt  <= '0;
      r_rx_bit   <= '0;
      r_rx_shift <= '0;
      r_rx_mode  <= '0;
      r_rx_stop2 <= 1'b0;
      r_rx_perr  <= 1'b0;
    end else begin
      r_rx_state <= w_rx_state_n;
      r_rx_tcnt  <= w_rx_tcnt_n;
      r_rx_bit   <= w_rx_bit_n;
      r_rx_shift <= w_rx_shift_n;
      r_rx_mode  <= w_rx_mode_n;
      r_rx_stop2 <= w_rx_stop2_n;
      r_rx_perr  <= w_rx_perr_n;
    end
  end

  // A start needs a high-to-low transition, so a line held low after a framing error is not re-read.
  always_comb begin
    w_rx_state_n = r_rx_state;
    w_rx_tcnt_n  = r_rx_tcnt;
    w_rx_bit_n   = r_rx_bit;
    w_rx_shift_n = r_rx_shift;
    w_rx_mode_n  = r_rx_mode;
    w_rx_stop2_n = r_rx_stop2;
    w_rx_perr_n  = r_rx_perr;
    w_rx_push    = 1'b0;
    w_perr_set   = 1'b0;
    w_ferr_set   = 1'b0;
    if (w_tick) begin
      if (r_rx_state == RX_IDLE) begin
        if (!w_rx_bit && r_rx_prev) begin
          w_rx_state_n = RX_START;
          w_rx_tcnt_n  = '0;
          w_rx_mode_n  = parity_mode;
          w_rx_stop2_n = stop2;
          w_rx_perr_n  = 1'b0;
        end
      end else if (r_rx_tcnt != w_rx_limit) begin
        w_rx_tcnt_n = r_rx_tcnt + TW'(1);
      end else begin
        w_rx_tcnt_n = '0;
        case (r_rx_state)
          RX_START: begin
            w_rx_state_n = w_rx_bit ? RX_IDLE : RX_DATA;
            w_rx_bit_n   = '0;
          end
          RX_DATA: begin
            w_rx_shift_n = {w_rx_bit, r_rx_shift[DATA_BITS-1:1]};
            if (r_rx_bit == BW'(DATA_BITS - 1))
              w_rx_state_n = (r_rx_mode == 2'd1 || r_rx_mode == 2'd2) ? RX_PARITY : RX_STOP1;
            else
              w_rx_bit_n = r_rx_bit + BW'(1);
          end
          RX_PARITY: begin
            if ((^r_rx_shift) ^ w_rx_bit ^ (r_rx_mode == 2'd2)) begin
              w_rx_perr_n = 1'b1;
              w_perr_set  = 1'b1;
            end
            w_rx_state_n = RX_STOP1;
          end
          RX_STOP1: begin
            if (!w_rx_bit) begin
              w_ferr_set   = 1'b1;
              w_rx_state_n = RX_IDLE;
            end else if (r_rx_stop2) begin
              w_rx_state_n = RX_STOP2;
            end else begin
              w_rx_push    = !r_rx_perr;
              w_rx_state_n = RX_IDLE;
            end
          end
          RX_STOP2: begin
            if (!w_rx_bit) w_ferr_set = 1'b1;
            else           w_rx_push  = !r_rx_perr;
            w_rx_state_n = RX_IDLE;
          end
          default: w_rx_state_n = RX_IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST_N || err_clr) begin
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      if (w_perr_set) parity_err <= 1'b1;
      if (w_ferr_set) frame_err  <= 1'b1;
      if (w_ovr_set)  overrun    <= 1'b1;
    end
  end

  uart_comm_param_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .CLK        (CLK),
    .RST_N      (RST_N),
    .i_push     (w_rx_push),
    .i_wdata    (r_rx_shift),
    .i_pop      (bus.recv_flag),
    .o_head     (bus.recv_data),
    .o_not_empty(bus.receivable),
    .o_not_full (w_rx_not_full)
  );

  // ---------------- TX FSM ----------------
  tx_state_t            r_tx_state, w_tx_state_n;
  logic [TW-1:0]        r_tx_tcnt, w_tx_tcnt_n;
  logic [BW-1:0]        r_tx_bit, w_tx_bit_n;
  logic [DATA_BITS-1:0] r_tx_shift, w_tx_shift_n;
  logic                 r_tx_paren, w_tx_paren_n;
  logic                 r_tx_par, w_tx_par_n;
  logic                 r_tx_stop2, w_tx_stop2_n;
  logic                 w_tx_n, w_tx_pop, w_tx_load, w_tx_bnd;
  logic [DATA_BITS-1:0] w_tx_head;
  logic                 w_tx_not_empty;

  assign w_tx_bnd = w_tick && (r_tx_tcnt == TW'(OVERSAMPLE - 1));

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      r_tx_state <= TX_IDLE;
      r_tx_tcnt  <= '0;
      r_tx_bit   <= '0;
      r_tx_shift <= '0;
      r_tx_paren <= 1'b0;
      r_tx_par   <= 1'b0;
      r_tx_stop2 <= 1'b0;
      r_tx       <= 1'b1;
    end else begin
      r_tx_state <= w_tx_state_n;
      r_tx_tcnt  <= w_tx_tcnt_n;
      r_tx_bit   <= w_tx_bit_n;
      r_tx_shift <= w_tx_shift_n;
      r_tx_paren <= w_tx_paren_n;
      r_tx_par   <= w_tx_par_n;
      r_tx_stop2 <= w_tx_stop2_n;
      r_tx       <= w_tx_n;
    end
  end

  // The last stop bit may chain straight into the next start, equivalent to one boundary spent in IDLE.
  always_comb begin
    w_tx_state_n = r_tx_state;
    w_tx_tcnt_n  = r_tx_tcnt;
    w_tx_bit_n   = r_tx_bit;
    w_tx_shift_n = r_tx_shift;
    w_tx_paren_n = r_tx_paren;
    w_tx_par_n   = r_tx_par;
    w_tx_stop2_n = r_tx_stop2;
    w_tx_n       = r_tx;
    w_tx_load    = 1'b0;
    w_tx_pop     = 1'b0;
    if (w_tick) w_tx_tcnt_n = w_tx_bnd ? '0 : r_tx_tcnt + TW'(1);
    if (w_tx_bnd) begin
      case (r_tx_state)
        TX_IDLE: w_tx_load = w_tx_not_empty;
        TX_START: begin
          w_tx_n       = r_tx_shift[0];
          w_tx_shift_n = r_tx_shift >> 1;
          w_tx_bit_n   = '0;
          w_tx_state_n = TX_DATA;
        end
        TX_DATA: begin
          if (r_tx_bit == BW'(DATA_BITS - 1)) begin
            w_tx_n       = r_tx_paren ? r_tx_par : 1'b1;
            w_tx_state_n = r_tx_paren ? TX_PARITY : TX_STOP1;
          end else begin
            w_tx_n       = r_tx_shift[0];
            w_tx_shift_n = r_tx_shift >> 1;
            w_tx_bit_n   = r_tx_bit + BW'(1);
          end
        end
        TX_PARITY: begin
          w_tx_n       = 1'b1;
          w_tx_state_n = TX_STOP1;
        end
        TX_STOP1: begin
          if (r_tx_stop2) begin
            w_tx_state_n = TX_STOP2;
          end else begin
            w_tx_state_n = TX_IDLE;
            w_tx_load    = w_tx_not_empty;
          end
        end
        TX_STOP2: begin
          w_tx_state_n = TX_IDLE;
          w_tx_load    = w_tx_not_empty;
        end
        default: w_tx_state_n = TX_IDLE;
      endcase
    end
    if (w_tx_load) begin
      w_tx_pop     = 1'b1;
      w_tx_state_n = TX_START;
      w_tx_n       = 1'b0;
      w_tx_shift_n = w_tx_head;
      w_tx_paren_n = (parity_mode == 2'd1) || (parity_mode == 2'd2);
      w_tx_par_n   = (^w_tx_head) ^ (parity_mode == 2'd2);
      w_tx_stop2_n = stop2;
    end
  end

  uart_comm_param_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .CLK        (CLK),
    .RST_N      (RST_N),
    .i_push     (bus.send_flag),
    .i_wdata    (bus.send_data),
    .i_pop      (w_tx_pop),
    .o_head     (w_tx_head),
    .o_not_empty(w_tx_not_empty),
    .o_not_full (bus.sendable)
  );
endmodule

// File: tb/tb_uart_comm_param.sv
// Self-checking bench for uart_comm_param: frame-level model of the serial protocol and RX FIFO.
// Define UART_LOOPBACK_EN to also exercise the loopback path.
module tb_uart_comm_param;
  localparam int unsigned DB    = 8;
  localparam int unsigned DEPTH = 16;
  localparam int unsigned BIT   = 16;

  logic CLK = 1'b0;
  logic RST_N = 1'b0;
  always #5 CLK = ~CLK;

  uart_comm_param_if #(.DATA_BITS(DB)) bus ();
  logic [1:0] parity_mode;
  logic       stop2, err_clr, Rx, Tx, parity_err, frame_err, overrun;
`ifdef UART_LOOPBACK_EN
  logic       loopback;
`endif

  uart_comm_param #(
    .CLOCKRATE (1600),
    .BAUDRATE  (100),
    .OVERSAMPLE(16),
    .DATA_BITS (DB),
    .FIFO_DEPTH(DEPTH)
  ) dut (
    .CLK        (CLK),
    .RST_N      (RST_N),
    .bus        (bus.slave),
    .parity_mode(parity_mode),
    .stop2      (stop2),
    .err_clr    (err_clr),
    .parity_err (parity_err),
    .frame_err  (frame_err),
    .overrun    (overrun),
    .Tx         (Tx),
    .Rx         (Rx)
`ifdef UART_LOOPBACK_EN
    , .loopback (loopback)
`endif
  );

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  logic [7:0]  exp_q[$];
  bit          exp_perr = 0, exp_ferr = 0, exp_ovr = 0;
  bit          chk_en = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Serial frame as seen on the wire, index 0 = start bit.
  function automatic void model_frame(input logic [7:0] d, input logic [1:0] mode, input bit s2,
                                      input bit flip_par, input bit bad_s2,
                                      output logic [11:0] bits, output int unsigned n);
    bits = '1;
    n = 0;
    bits[n] = 1'b0; n++;
    for (int unsigned i = 0; i < DB; i++) begin bits[n] = d[i]; n++; end
    if (mode == 2'd1 || mode == 2'd2) begin
      bits[n] = (^d) ^ (mode == 2'd2) ^ flip_par; n++;
    end
    bits[n] = 1'b1; n++;
    if (s2) begin bits[n] = !bad_s2; n++; end
  endfunction

  always @(negedge CLK) begin
    if (chk_en) begin
      check("receivable", bus.receivable, exp_q.size() != 0);
      if (exp_q.size() != 0) check("recv_data", bus.recv_data, exp_q[0]);
      check("parity_err", parity_err, exp_perr);
      check("frame_err", frame_err, exp_ferr);
      check("overrun", overrun, exp_ovr);
      check("tx_idle", Tx, 1'b1);
      check("sendable", bus.sendable, 1'b1);
    end
  end

  task automatic tick(input int unsigned n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic rx_frame(input logic [7:0] d, input bit flip_par, input bit bad_s2);
    logic [11:0] bits;
    int unsigned n;
    bit par_ok, stop_ok;
    model_frame(d, parity_mode, stop2, flip_par, bad_s2, bits, n);
    chk_en = 0;
    for (int unsigned i = 0; i < n; i++) begin Rx = bits[i]; tick(BIT); end
    Rx = 1'b1;
    tick(3 * BIT);
    par_ok  = !((parity_mode == 2'd1 || parity_mode == 2'd2) && flip_par);
    stop_ok = !(stop2 && bad_s2);
    if (!par_ok)  exp_perr = 1;
    if (!stop_ok) exp_ferr = 1;
    if (par_ok && stop_ok) begin
      if (exp_q.size() < DEPTH) exp_q.push_back(d);
      else exp_ovr = 1;
    end
    chk_en = 1;
  endtask

  task automatic pop_one();
    bus.recv_flag = 1'b1;
    tick(1);
    bus.recv_flag = 1'b0;
    void'(exp_q.pop_front());
  endtask

  task automatic clear_errs();
    err_clr = 1'b1;
    tick(1);
    err_clr = 1'b0;
    exp_perr = 0; exp_ferr = 0; exp_ovr = 0;
  endtask

  // Push one word, then sample Tx in the middle of every bit; mode/stop2 are changed mid-frame.
  task automatic tx_check(input logic [7:0] d, input logic [11:0] lit);
    logic [11:0] bits;
    int unsigned n, lat;
    logic [1:0]  m0;
    bit          s0;
    m0 = parity_mode; s0 = stop2;
    model_frame(d, m0, s0, 1'b0, 1'b0, bits, n);
    chk_en = 0;
    bus.send_data = d; bus.send_flag = 1'b1;
    tick(1);
    bus.send_flag = 1'b0;
    @(negedge CLK); lat = 1;
    while (Tx !== 1'b0 && lat < 40) begin @(negedge CLK); lat++; end
    check("tx_start_latency_ok", lat <= 18, 1'b1);
    repeat (BIT / 2) @(negedge CLK);
    for (int unsigned i = 0; i < n; i++) begin
      if (i != 0) repeat (BIT) @(negedge CLK);
      check($sformatf("tx_bit%0d", i), Tx, bits[i]);
      check($sformatf("tx_bit%0d_lit", i), Tx, lit[i]);
      if (i == 1) begin parity_mode = ~m0; stop2 = ~s0; end
    end
    repeat (BIT) @(negedge CLK);
    check("tx_after_frame", Tx, 1'b1);
    parity_mode = m0; stop2 = s0;
    tick(1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    Rx = 1'b1; bus.send_flag = 1'b0; bus.send_data = '0; bus.recv_flag = 1'b0;
    parity_mode = 2'd0; stop2 = 1'b0; err_clr = 1'b0;
`ifdef UART_LOOPBACK_EN
    loopback = 1'b0;
`endif
    tick(3);
    @(negedge CLK);
    check("rst_tx", Tx, 1'b1);
    check("rst_sendable", bus.sendable, 1'b1);
    check("rst_receivable", bus.receivable, 1'b0);
    check("rst_recv_data", bus.recv_data, 8'h00);
    check("rst_flags", {parity_err, frame_err, overrun}, 3'b000);
    tick(1);
    RST_N = 1'b1;
    tick(2);
    chk_en = 1;

    // TX framing
    parity_mode = 2'd1; stop2 = 1'b0;
    tx_check(8'hA5, 12'h54A);
    parity_mode = 2'd2; stop2 = 1'b1;
    tx_check(8'h3C, 12'hE78);
    parity_mode = 2'd0; stop2 = 1'b0;
    tick(2 * BIT);
    chk_en = 1;

    // RX good frame, odd parity
    parity_mode = 2'd2;
    rx_frame(8'h3C, 1'b0, 1'b0);
    check("rx_3c_lit", bus.recv_data, 8'h3C);
    pop_one();

    // RX parity error, even mode
    parity_mode = 2'd1;
    rx_frame(8'h3C, 1'b1, 1'b0);
    check("perr_lit", parity_err, 1'b1);
    check("perr_no_word", bus.receivable, 1'b0);
    clear_errs();
    tick(1);
    check("perr_cleared", parity_err, 1'b0);

    // RX frame error on second stop bit
    parity_mode = 2'd0; stop2 = 1'b1;
    rx_frame(8'h81, 1'b0, 1'b1);
    check("ferr_lit", frame_err, 1'b1);
    clear_errs();
    parity_mode = 2'd3;
    rx_frame(8'h81, 1'b0, 1'b0);
    pop_one();
    stop2 = 1'b0;

    // 4-clock glitch must not start a frame
    Rx = 1'b0; tick(4); Rx = 1'b1;
    tick(4 * BIT);
    check("glitch_no_word", bus.receivable, 1'b0);
    parity_mode = 2'd1;
    rx_frame(8'h5B, 1'b0, 1'b0);
    pop_one();

    // Overrun: 17 words, none popped
    parity_mode = 2'd0;
    for (int unsigned i = 0; i < DEPTH + 1; i++) rx_frame(8'h10 + 8'(i), 1'b0, 1'b0);
    check("ovr_lit", overrun, 1'b1);
    check("ovr_head_lit", bus.recv_data, 8'h10);
    while (exp_q.size() != 0) pop_one();
    tick(2);
    clear_errs();
    tick(2);

    // TX FIFO fill, then reset mid-frame
    chk_en = 0;
    bus.send_data = 8'h00; bus.send_flag = 1'b1;
    tick(20);
    bus.send_flag = 1'b0;
    tick(2);
    @(negedge CLK);
    check("tx_fifo_full", bus.sendable, 1'b0);
    check("tx_busy_low", Tx, 1'b0);
    tick(20);
    RST_N = 1'b0;
    tick(1);
    @(negedge CLK);
    check("midrst_tx", Tx, 1'b1);
    check("midrst_sendable", bus.sendable, 1'b1);
    RST_N = 1'b1;
    exp_q.delete();
    tick(2);
    chk_en = 1;
    tick(3 * BIT);

`ifdef UART_LOOPBACK_EN
    chk_en = 0;
    loopback = 1'b1; Rx = 1'b0;
    parity_mode = 2'd1;
    bus.send_data = 8'h5A; bus.send_flag = 1'b1;
    tick(1);
    bus.send_flag = 1'b0;
    for (int unsigned i = 0; i < 14 * BIT; i++) begin
      @(negedge CLK);
      if (i % 8 == 0) check("lb_tx_high", Tx, 1'b1);
    end
    tick(1);
    check("lb_recv_lit", bus.recv_data, 8'h5A);
    exp_q.push_back(8'h5A);
    Rx = 1'b1;
    loopback = 1'b0;
    chk_en = 1;
    tick(2);
    pop_one();
    parity_mode = 2'd0;
    tick(BIT);
`endif

    chk_en = 0;
    tick(2);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
